// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alarm_pkg                                              |
// | Description : State encoding and counter width helpers for the       |
// |               lights/door/ignition warning controller.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRACE = 2'd1,
        SOUND = 2'd2,
        MUTED = 2'd3
    } alarmState_t;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int cntW(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int c_DEF_GRACE_W = cntW(10);
    localparam int c_DEF_PHASE_W = cntW(3 + 2);
    localparam int c_DEF_BEEP_W  = cntW(3);

endpackage
`default_nettype wire

// File: rtl/alarm_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alarm_debounce                                         |
// | Description : Filters one raw body input; the filtered copy follows  |
// |               only after DEB_CYC consecutive differing samples.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alarm_debounce
    import alarm_pkg::*;
#(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filtered
);

    localparam int                 c_CNT_W   = cntW(DEB_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_TOP = c_CNT_W'(DEB_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (raw == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_TOP) begin
            r_cnt  <= '0;
            r_filt <= raw;
        end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign filtered = r_filt;

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alarm_ctrl                                             |
// | Description : Debounced lights-on/door-open/ignition-off warning     |
// |               with grace delay, bounded beep pattern and mute.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int DEB_CYC   = 4,
    parameter int GRACE_CYC = 10,
    parameter int ON_CYC    = 3,
    parameter int OFF_CYC   = 2,
    parameter int MAX_BEEPS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sLuz,
    input  logic       sPrta,
    input  logic       sIgn,
    input  logic       sAck,
    output logic       sAlarm,
    output logic [1:0] sState
);

    localparam int c_GRACE_W = cntW(GRACE_CYC);
    localparam int c_PHASE_W = cntW(ON_CYC + OFF_CYC);
    localparam int c_BEEP_W  = cntW(MAX_BEEPS);

    localparam logic [c_GRACE_W-1:0] c_GRACE_LOAD = c_GRACE_W'(GRACE_CYC - 1);
    localparam logic [c_GRACE_W-1:0] c_GRACE_ONE  = c_GRACE_W'(1);
    localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(ON_CYC + OFF_CYC - 1);
    localparam logic [c_PHASE_W-1:0] c_PHASE_ON   = c_PHASE_W'(ON_CYC);
    localparam logic [c_PHASE_W-1:0] c_PHASE_ONE  = c_PHASE_W'(1);
    localparam logic [c_BEEP_W-1:0]  c_BEEP_LAST  = c_BEEP_W'(MAX_BEEPS - 1);
    localparam logic [c_BEEP_W-1:0]  c_BEEP_ONE   = c_BEEP_W'(1);

    logic w_fLuz;
    logic w_fPrta;
    logic w_fIgn;
    logic w_cond;

    alarm_debounce #(.DEB_CYC(DEB_CYC)) u_debLuz (
        .clk      (clk),
        .rst      (rst),
        .raw      (sLuz),
        .filtered (w_fLuz)
    );

    alarm_debounce #(.DEB_CYC(DEB_CYC)) u_debPrta (
        .clk      (clk),
        .rst      (rst),
        .raw      (sPrta),
        .filtered (w_fPrta)
    );

    alarm_debounce #(.DEB_CYC(DEB_CYC)) u_debIgn (
        .clk      (clk),
        .rst      (rst),
        .raw      (sIgn),
        .filtered (w_fIgn)
    );

    assign w_cond = w_fLuz & w_fPrta & ~w_fIgn;

    alarmState_t          r_state;
    alarmState_t          w_nextState;
    logic [c_GRACE_W-1:0] r_graceCnt;
    logic [c_GRACE_W-1:0] w_nextGrace;
    logic [c_PHASE_W-1:0] r_phase;
    logic [c_PHASE_W-1:0] w_nextPhase;
    logic [c_BEEP_W-1:0]  r_beep;
    logic [c_BEEP_W-1:0]  w_nextBeep;
    logic                 r_alarm;
    logic                 w_nextAlarm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_graceCnt <= '0;
            r_phase    <= '0;
            r_beep     <= '0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_graceCnt <= w_nextGrace;
            r_phase    <= w_nextPhase;
            r_beep     <= w_nextBeep;
            r_alarm    <= w_nextAlarm;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextGrace = r_graceCnt;
        w_nextPhase = r_phase;
        w_nextBeep  = r_beep;
        w_nextAlarm = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cond) begin
                    w_nextState = GRACE;
                    w_nextGrace = c_GRACE_LOAD;
                end
            end
            GRACE: begin
                if (!w_cond) begin
                    w_nextState = IDLE;
                end else if (sAck) begin
                    w_nextState = MUTED;
                end else if (r_graceCnt == '0) begin
                    // Siren rises together with the state change, phase 0 is "on".
                    w_nextState = SOUND;
                    w_nextPhase = '0;
                    w_nextBeep  = '0;
                    w_nextAlarm = 1'b1;
                end else begin
                    w_nextGrace = r_graceCnt - c_GRACE_ONE;
                end
            end
            SOUND: begin
                if (!w_cond) begin
                    w_nextState = IDLE;
                end else if (sAck) begin
                    w_nextState = MUTED;
                end else if (r_phase == c_PHASE_LAST && r_beep == c_BEEP_LAST) begin
                    w_nextState = MUTED;
                end else begin
                    if (r_phase == c_PHASE_LAST) begin
                        w_nextPhase = '0;
                        w_nextBeep  = r_beep + c_BEEP_ONE;
                    end else begin
                        w_nextPhase = r_phase + c_PHASE_ONE;
                    end
                    w_nextAlarm = (w_nextPhase < c_PHASE_ON);
                end
            end
            MUTED: begin
                if (!w_cond) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign sAlarm = r_alarm;
    assign sState = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alarm_ctrl                                          |
// | Description : Scoreboard bench for alarm_ctrl with default timing.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sLuz = 1'b0;
    logic       sPrta = 1'b0;
    logic       sIgn = 1'b0;
    logic       sAck = 1'b0;
    logic       sAlarm;
    logic [1:0] sState;

    alarm_ctrl #(
        .DEB_CYC   (4),
        .GRACE_CYC (10),
        .ON_CYC    (3),
        .OFF_CYC   (2),
        .MAX_BEEPS (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sLuz   (sLuz),
        .sPrta  (sPrta),
        .sIgn   (sIgn),
        .sAck   (sAck),
        .sAlarm (sAlarm),
        .sState (sState)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       al;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   base   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every edge's expectation is tagged with its absolute edge number.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for edge %0d not checked (now edge %0d)", e.tag, e.cyc, cyc);
            end else if (sState !== e.st || sAlarm !== e.al) begin
                errors++;
                $display("FAIL %s edge %0d: got state=%0d alarm=%0b, want state=%0d alarm=%0b",
                         e.tag, e.cyc - base, sState, sAlarm, e.st, e.al);
            end
        end
    end

    task automatic push(input int k, input logic [1:0] st, input logic al, input string tag);
        exp_t e;
        e.cyc = base + k;
        e.st  = st;
        e.al  = al;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hand-derived timeline of the undisturbed full sequence (edge k after cycle 0).
    function automatic logic [1:0] fullSt(input int k);
        if (k < 5)  return 2'd0;
        if (k < 15) return 2'd1;
        if (k < 30) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic fullAl(input int k);
        return (k >= 15 && k <= 17) || (k >= 20 && k <= 22) || (k >= 25 && k <= 27);
    endfunction

    task automatic pushFull(input int from, input int to, input string tag);
        for (int k = from; k <= to; k++) push(k, fullSt(k), fullAl(k), tag);
    endtask

    task automatic doReset();
        rst   = 1'b1;
        sLuz  = 1'b1;
        sPrta = 1'b1;
        sIgn  = 1'b0;
        sAck  = 1'b1;
        base  = cyc;
        push(1, 2'd0, 1'b0, "reset");
        push(2, 2'd0, 1'b0, "reset");
        waitEdges(2);
        rst   = 1'b0;
        sLuz  = 1'b0;
        sPrta = 1'b0;
        sAck  = 1'b0;
        base  = cyc;
        for (int k = 1; k <= 3; k++) push(k, 2'd0, 1'b0, "postReset");
        waitEdges(3);
    endtask

    task automatic startCond();
        base  = cyc;
        sLuz  = 1'b1;
        sPrta = 1'b1;
        sIgn  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full sequence
        doReset();
        startCond();
        pushFull(1, 34, "full");
        waitEdges(34);

        // Glitch rejection on the door input
        doReset();
        base  = cyc;
        sLuz  = 1'b1;
        sIgn  = 1'b0;
        sPrta = 1'b1;
        for (int k = 1; k <= 15; k++) push(k, 2'd0, 1'b0, "glitch");
        waitEdges(3);
        sPrta = 1'b0;
        waitEdges(12);

        // Acknowledge during sound, ack ignored while muted, door drop to idle
        doReset();
        startCond();
        pushFull(1, 21, "ackPre");
        for (int k = 22; k <= 29; k++) push(k, 2'd3, 1'b0, "ackMuted");
        for (int k = 30; k <= 33; k++) push(k, 2'd0, 1'b0, "ackIdle");
        waitEdges(21);
        sAck = 1'b1;
        waitEdges(1);
        sAck = 1'b0;
        waitEdges(3);
        sPrta = 1'b0;
        waitEdges(2);
        sAck = 1'b1;
        waitEdges(1);
        sAck = 1'b0;
        waitEdges(5);

        // Ignition during sound, ack on the same edge loses to !cond
        doReset();
        startCond();
        pushFull(1, 20, "ignPre");
        for (int k = 21; k <= 26; k++) push(k, 2'd0, 1'b0, "ignIdle");
        waitEdges(16);
        sIgn = 1'b1;
        waitEdges(4);
        sAck = 1'b1;
        waitEdges(1);
        sAck = 1'b0;
        waitEdges(5);

        // Reset in the middle of sound, then full re-entry
        doReset();
        startCond();
        pushFull(1, 22, "rstPre");
        for (int k = 23; k <= 27; k++) push(k, 2'd0, 1'b0, "rstMid");
        for (int k = 28; k <= 37; k++) push(k, 2'd1, 1'b0, "rstGrace");
        for (int k = 38; k <= 40; k++) push(k, 2'd2, 1'b1, "rstSound");
        waitEdges(22);
        rst = 1'b1;
        waitEdges(1);
        rst = 1'b0;
        waitEdges(17);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
            errors += q.size();
            checks += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_ctrl.md
# alarm_ctrl

Sequential controller for the vehicle "lights-on, door-open, ignition-off" warning. It debounces the three raw body signals and forms the alarm condition from them. It then applies a grace delay and drives the siren with a bounded beep pattern. The driver can silence it with an acknowledge. It sits between the raw body-sensor inputs and the siren driver, and replaces the direct combinational alarm decode.

## Interface
Parameters:
- `DEB_CYC`, default 4: cycles a raw input must hold a new value before its filtered copy changes; must be ≥1.
- `GRACE_CYC`, default 10: cycles the condition must persist before sounding; must be ≥1.
- `ON_CYC`, default 3: siren high cycles per beep; must be ≥1.
- `OFF_CYC`, default 2: siren low cycles per beep; must be ≥1.
- `MAX_BEEPS`, default 3: complete beeps before auto-mute; must be ≥1.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `sLuz`  in  1: raw lights-on.
- `sPrta`  in  1: raw door-open.
- `sIgn`  in  1: raw ignition-on.
- `sAck`  in  1: driver acknowledge/mute; level, sampled each cycle.
- `sAlarm`  out  1: siren drive, registered.
- `sState`  out  2: current FSM state, registered.

## Operation
- **Debounce, per input.**
  - A counter increments while raw ≠ filtered and clears when raw = filtered.
  - When raw ≠ filtered and the counter = `DEB_CYC`−1, filtered takes the raw value and the counter clears.
- **Condition.** `cond = fLuz & fPrta & ~fIgn`, decoded combinationally from the filtered values.
- **FSM states.** `IDLE`=0, `GRACE`=1, `SOUND`=2, `MUTED`=3.
  - **IDLE:** if `cond`, go to GRACE and load the grace counter with `GRACE_CYC`−1.
  - **GRACE**, priority `!cond` > `sAck` > timeout:
    - `!cond` → IDLE.
    - `sAck` → MUTED.
    - Grace counter = 0 → SOUND; clear the phase and beep counters.
    - Otherwise decrement the grace counter.
  - **SOUND**, priority `!cond` > `sAck` > beep limit:
    - `!cond` → IDLE.
    - `sAck` → MUTED.
    - Phase counter walks 0..`ON_CYC`+`OFF_CYC`−1.
    - `sAlarm` = 1 while phase < `ON_CYC`, else 0.
    - At the last phase of beep number `MAX_BEEPS` → MUTED.
  - **MUTED:** `sAlarm` = 0; leave to IDLE only when `!cond`. `sAck` is ignored here.
- `sAck` is ignored in IDLE.
- **Reset values.** `sAlarm`=0, `sState`=IDLE, filtered inputs=0, all counters=0.

## Timing
- A raw change held for `DEB_CYC` cycles appears in the filtered copy at the `DEB_CYC`-th edge after it was first sampled.
- The FSM reacts to `cond` one edge after the filtered value changes.
- In GRACE the FSM spends exactly `GRACE_CYC` cycles.
- `sAlarm` rises on the same edge that `sState` becomes SOUND.
- Each beep is `ON_CYC` cycles high followed by `OFF_CYC` cycles low.
- The transition to MUTED after the limit occurs on the edge ending the last OFF phase, i.e. `MAX_BEEPS`·(`ON_CYC`+`OFF_CYC`) cycles after SOUND entry.
- Exits from SOUND caused by `!cond` or `sAck` drop `sAlarm` on the same edge as the state change, i.e. one edge after the cause.
- A raw pulse shorter than `DEB_CYC` cycles never reaches the FSM.
- `rst` asserted in any state returns every register to its reset value at that edge, overriding all other conditions.
- Re-entry: after IDLE, a persisting `cond` restarts GRACE with the full count.

## Structure
- **`alarm_pkg`** holds:
  - the state enum (`IDLE`/`GRACE`/`SOUND`/`MUTED`, 2 bits);
  - width helper constants derived via `$clog2` for the grace, phase and beep counters.
- **`alarm_debounce`** (parameter `DEB_CYC`; ports `clk`, `rst`, raw in, filtered out) is a sub-module instantiated three times.
- The FSM, counters and output registers live in `alarm_ctrl`.

## Test plan
All scenarios use the defaults `DEB_CYC`=4, `GRACE_CYC`=10, `ON_CYC`=3, `OFF_CYC`=2, `MAX_BEEPS`=3.
- **Reset.** Hold `rst` for 2 cycles with arbitrary inputs → `sAlarm`=0, `sState`=0 at every edge during and after `rst` while inputs are idle.
- **Full sequence.** At cycle 0 drive `sLuz`=1, `sPrta`=1, `sIgn`=0 and hold → expect:
  - filtered values at edge 4;
  - GRACE at edge 5;
  - SOUND at edge 15;
  - `sAlarm` high on edges 15–17, 20–22 and 25–27, low otherwise;
  - MUTED at edge 30, staying muted while the condition holds.
- **Glitch rejection.** Lights on and ignition off held, `sPrta` pulsed for 3 cycles → `sState` stays 0 and `sAlarm` stays 0.
- **Acknowledge.** Assert `sAck` for 1 cycle at edge 21 of the full sequence → MUTED and `sAlarm`=0 at edge 22. Then drop `sPrta` → IDLE 5 edges after the drop.
- **Ignition during sound.** Raise `sIgn` at edge 16 → IDLE and `sAlarm`=0 at edge 21. Check that `sAck` asserted in the same window changes nothing, since `!cond` has priority.
- **Reset mid-sound.** Assert `rst` at edge 23 → `sAlarm`=0 and `sState`=0 at edge 23. Release with the condition still held → GRACE 5 edges later, then a full 10-cycle grace before sound.
